// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared definitions for the sqrt result packer.
//   state_e        FSM state encoding.
//   EXP_*          binary16 exponent constants.
//   QNAN_NEG/PINF  fixed encodings for the special-class outputs.
package sqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_PACK = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam int EXP_BIAS      = 15;
  localparam int EXP_MIN_NORM  = -14;
  localparam int EXP_FIELD_MAX = 31;

  localparam logic [15:0] QNAN_NEG = 16'hFE00;
  localparam logic [15:0] PINF     = 16'h7C00;

endpackage

// File: rtl/sqrt_pack_if.sv
// sqrt_pack_if: iterator-side inputs and packed-result outputs of sqrt_pack.
//   master  drives the iterator beats and out_ready, observes results/status.
//   slave   the packer itself.
interface sqrt_pack_if;
  logic              it_valid;
  logic              result;
  logic              sign_in;
  logic signed [6:0] exp_in;
  logic [10:0]       mant_in;
  logic              is_nan_in;
  logic              is_pinf_in;
  logic              is_ninf_in;
  logic              out_ready;
  logic              out_valid;
  logic [15:0]       out_data;
  logic              busy;
  logic [3:0]        beat_cnt;
  logic              drop_sticky;

  modport master (
    output it_valid, result, sign_in, exp_in, mant_in,
           is_nan_in, is_pinf_in, is_ninf_in, out_ready,
    input  out_valid, out_data, busy, beat_cnt, drop_sticky
  );

  modport slave (
    input  it_valid, result, sign_in, exp_in, mant_in,
           is_nan_in, is_pinf_in, is_ninf_in, out_ready,
    output out_valid, out_data, busy, beat_cnt, drop_sticky
  );
endinterface

// File: rtl/sqrt_pack_fmt.sv
// sqrt_pack_fmt: combinational binary16 encoder for a normalised operand.
//   sign_i/exp_i/mant_i  operand, value = mant_i/1024 * 2^exp_i
//   nan_i/pinf_i/ninf_i  special-class flags
//   data_o               binary16 encoding, truncated (no rounding)
module sqrt_pack_fmt
  import sqrt_pkg::*;
(
  input  logic              sign_i,
  input  logic signed [6:0] exp_i,
  input  logic [10:0]       mant_i,
  input  logic              nan_i,
  input  logic              pinf_i,
  input  logic              ninf_i,
  output logic [15:0]       data_o
);

  logic signed [8:0] exp_ext;
  logic signed [8:0] biased;
  logic signed [8:0] shift;
  logic [10:0]       sub_mant;

  always_comb begin
    exp_ext  = {{2{exp_i[6]}}, exp_i};
    biased   = exp_ext + 9'(EXP_BIAS);
    shift    = 9'sd1 - biased;
    // Subnormal fraction: right shift by (1 - biased); shifting 11 or more
    // places leaves nothing. A non-positive shift only occurs for biased==1
    // with a clear integer bit, where the mantissa is already the fraction.
    sub_mant = '0;
    if (shift <= 9'sd0)
      sub_mant = mant_i;
    else if (shift < 9'sd11)
      sub_mant = mant_i >> shift[3:0];

    if (nan_i || ninf_i)
      data_o = QNAN_NEG;
    else if (pinf_i)
      data_o = PINF;
    else if (mant_i == '0)
      data_o = {sign_i, 15'b0};
    else if (biased >= 9'(EXP_FIELD_MAX))
      data_o = {sign_i, PINF[14:0]};
    else if ((biased >= 9'sd1) && mant_i[10])
      data_o = {sign_i, biased[4:0], mant_i[9:0]};
    else
      data_o = {sign_i, 5'b0, sub_mant[9:0]};
  end

endmodule

// File: rtl/sqrt_pack.sv
// sqrt_pack: captures the final beat of the sqrt iterator, normalises the
// mantissa one bit per cycle, packs it to binary16 and holds it until taken.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         sqrt_pack_if.slave (iterator beats in, packed result out)
// Build option: SQRT_PACK_STATS_EN enables beat_cnt and drop_sticky;
// without it both outputs are tied low.
//
//   state | meaning
//   IDLE  | waiting for a final beat, counting non-final beats
//   NORM  | shifting mantissa left until normalised or exponent floor hit
//   PACK  | register the encoded result
//   HOLD  | result presented until out_ready
module sqrt_pack
  import sqrt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  sqrt_pack_if.slave  bus
);

  state_e            state_q, state_d;
  logic              sign_q;
  logic signed [6:0] exp_q;
  logic [10:0]       mant_q;
  logic              nan_q, pinf_q, ninf_q;
  logic [15:0]       out_data_q;
  logic              out_valid_q;
  logic [15:0]       fmt_data;
  logic              capture;
  logic              norm_done;

  assign capture   = (state_q == ST_IDLE) && bus.it_valid && bus.result;
  assign norm_done = nan_q || pinf_q || ninf_q || (mant_q == '0) || mant_q[10] ||
                     (exp_q <= 7'(EXP_MIN_NORM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (capture) state_d = ST_NORM;
      ST_NORM: if (norm_done) state_d = ST_PACK;
      ST_PACK: state_d = ST_HOLD;
      ST_HOLD: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      nan_q       <= 1'b0;
      pinf_q      <= 1'b0;
      ninf_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (capture) begin
        sign_q <= bus.sign_in;
        exp_q  <= bus.exp_in;
        mant_q <= bus.mant_in;
        nan_q  <= bus.is_nan_in;
        pinf_q <= bus.is_pinf_in;
        ninf_q <= bus.is_ninf_in;
      end
      if ((state_q == ST_NORM) && !norm_done) begin
        mant_q <= mant_q << 1;
        exp_q  <= exp_q - 7'sd1;
      end
      if (state_q == ST_PACK) begin
        out_data_q  <= fmt_data;
        out_valid_q <= 1'b1;
      end
      if ((state_q == ST_HOLD) && bus.out_ready)
        out_valid_q <= 1'b0;
    end
  end

  sqrt_pack_fmt u_fmt (
    .sign_i (sign_q),
    .exp_i  (exp_q),
    .mant_i (mant_q),
    .nan_i  (nan_q),
    .pinf_i (pinf_q),
    .ninf_i (ninf_q),
    .data_o (fmt_data)
  );

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

`ifdef SQRT_PACK_STATS_EN
  logic [3:0] beat_cnt_q;
  logic       drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      if (capture)
        beat_cnt_q <= '0;
      else if ((state_q == ST_IDLE) && bus.it_valid && !bus.result && (beat_cnt_q != 4'hF))
        beat_cnt_q <= beat_cnt_q + 4'd1;
      if ((state_q != ST_IDLE) && bus.it_valid && bus.result)
        drop_q <= 1'b1;
    end
  end

  assign bus.beat_cnt    = beat_cnt_q;
  assign bus.drop_sticky = drop_q;
`else
  assign bus.beat_cnt    = 4'd0;
  assign bus.drop_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_pack.sv
module tb_sqrt_pack;

`ifdef SQRT_PACK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sqrt_pack_if bus();

  sqrt_pack dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              s;
    logic signed [6:0] e;
    logic [10:0]       m;
    logic              nan;
    logic              pinf;
    logic              ninf;
    logic [15:0]       d;
    int                lat;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  // Reference: normalise by doubling until the integer bit is set or the
  // exponent reaches the smallest normal exponent, then encode the value
  // mm * 2^(ee-10) as binary16 with truncation.
  function automatic void model(input logic s, input int e, input int m,
                                input logic nan, input logic pinf, input logic ninf,
                                output logic [15:0] d, output int lat);
    int ee;
    int mm;
    int k;
    int sh;
    ee = e;
    mm = m;
    k  = 0;
    if (!(nan || pinf || ninf) && (m != 0)) begin
      while (mm < 1024 && ee > -14) begin
        mm = mm * 2;
        ee = ee - 1;
        k++;
      end
    end
    lat = 2 + k;
    if (nan || ninf)               d = 16'hFE00;
    else if (pinf)                 d = 16'h7C00;
    else if (m == 0)               d = {s, 15'b0};
    else if (ee + 15 >= 31)        d = {s, 15'h7C00};
    else if (mm >= 1024 && ee >= -14)
      d = {s, 5'(ee + 15), 10'(mm % 1024)};
    else begin
      // fraction counts units of 2^-24: mm * 2^(ee+14)
      sh = -(ee + 14);
      d  = {s, 5'b0, (sh >= 11) ? 10'd0 : 10'(mm >> sh)};
    end
  endfunction

  task automatic drive_beat(input logic fin, input logic s, input logic [6:0] e,
                            input logic [10:0] m, input logic nan, input logic pinf,
                            input logic ninf);
    bus.sign_in    = s;
    bus.exp_in     = e;
    bus.mant_in    = m;
    bus.is_nan_in  = nan;
    bus.is_pinf_in = pinf;
    bus.is_ninf_in = ninf;
    bus.it_valid   = 1'b1;
    bus.result     = fin;
    @(posedge clk);
    #1;
    bus.it_valid   = 1'b0;
    bus.result     = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_op(input string nm, input logic s, input logic [6:0] e,
                        input logic [10:0] m, input logic nan, input logic pinf,
                        input logic ninf, input logic [15:0] ed, input int el);
    int lat;
    drive_beat(1'b1, s, e, m, nan, pinf, ninf);
    wait_valid(lat);
    chk({nm, " latency"}, lat, el);
    chk({nm, " data"}, bus.out_data, ed);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({nm, " release"}, {bus.out_valid, bus.busy}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   seen;
    logic [15:0] ed;
    int   el;
    logic rs;
    logic [6:0] re;
    logic [10:0] rm;
    logic rn, rp, ri;
    int   r;

    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    bus.it_valid = 0; bus.result = 0; bus.sign_in = 0; bus.exp_in = '0;
    bus.mant_in = '0; bus.is_nan_in = 0; bus.is_pinf_in = 0; bus.is_ninf_in = 0;
    bus.out_ready = 0;

    tbl[0]  = '{1'b0,  7'sd1,   11'h400, 0, 0, 0, 16'h4000, 2};
    tbl[1]  = '{1'b0,  7'sd0,   11'h100, 0, 0, 0, 16'h3400, 4};
    tbl[2]  = '{1'b1, -7'sd15,  11'h000, 0, 0, 0, 16'h8000, 2};
    tbl[3]  = '{1'b0,  7'sd5,   11'h123, 1, 0, 0, 16'hFE00, 2};
    tbl[4]  = '{1'b1,  7'sd2,   11'h400, 0, 1, 0, 16'h7C00, 2};
    tbl[5]  = '{1'b0,  7'sd2,   11'h400, 0, 0, 1, 16'hFE00, 2};
    tbl[6]  = '{1'b0, -7'sd15,  11'h400, 0, 0, 0, 16'h0200, 2};
    tbl[7]  = '{1'b0,  7'sd16,  11'h400, 0, 0, 0, 16'h7C00, 2};
    tbl[8]  = '{1'b0, -7'sd14,  11'h001, 0, 0, 0, 16'h0001, 2};
    tbl[9]  = '{1'b0,  7'sd20,  11'h001, 0, 0, 0, 16'h6400, 12};
    tbl[10] = '{1'b0, -7'sd10,  11'h001, 0, 0, 0, 16'h0010, 6};
    tbl[11] = '{1'b1, -7'sd30,  11'h7FF, 0, 0, 0, 16'h8000, 2};
    tbl[12] = '{1'b0, -7'sd20,  11'h7FF, 0, 0, 0, 16'h001F, 2};
    tbl[13] = '{1'b1,  7'sd3,   11'h600, 0, 0, 0, 16'hCA00, 2};

    #12;
    chk("reset outputs", {bus.out_valid, bus.out_data, bus.busy, bus.beat_cnt, bus.drop_sticky}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].s, tbl[i].e, tbl[i].m,
             tbl[i].nan, tbl[i].pinf, tbl[i].ninf, tbl[i].d, tbl[i].lat);

    // Result held while out_ready is low; a final beat in HOLD is dropped.
    drive_beat(1'b1, 1'b0, 7'sd1, 11'h400, 0, 0, 0);
    wait_valid(lat);
    chk("hold latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold stable", {bus.out_valid, bus.out_data}, {1'b1, 16'h4000});
    end
    drive_beat(1'b1, 1'b1, 7'sd5, 11'h7FF, 0, 0, 0);
    chk("hold after drop", {bus.out_valid, bus.busy, bus.out_data}, {2'b11, 16'h4000});
    chk("drop sticky set", bus.drop_sticky, STATS);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("hold release", {bus.out_valid, bus.busy}, 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || bus.busy) seen = 1;
    end
    chk("dropped beat not captured", seen, 0);
    chk("drop sticky persists", bus.drop_sticky, STATS);

    rst_n = 1'b0;
    #2;
    chk("drop sticky reset", bus.drop_sticky, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Non-final beats counted in IDLE, cleared by capture, ignored in NORM.
    for (int i = 0; i < 5; i++) drive_beat(1'b0, 0, 7'sd0, 11'h0, 0, 0, 0);
    chk("beat count 5", bus.beat_cnt, STATS ? 4'd5 : 4'd0);
    drive_beat(1'b1, 1'b0, 7'sd20, 11'h001, 0, 0, 0);
    chk("beat count cleared", bus.beat_cnt, 0);
    drive_beat(1'b0, 0, 7'sd0, 11'h0, 0, 0, 0);
    chk("beat ignored in norm", {bus.beat_cnt, bus.busy}, {4'd0, 1'b1});
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("reset mid norm", {bus.out_valid, bus.out_data, bus.busy, bus.beat_cnt, bus.drop_sticky}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || bus.busy) seen = 1;
    end
    chk("no output after reset", seen, 0);

    for (int i = 0; i < 20; i++) drive_beat(1'b0, 0, 7'sd0, 11'h0, 0, 0, 0);
    chk("beat count saturates", bus.beat_cnt, STATS ? 4'd15 : 4'd0);
    run_op("after saturate", 1'b0, 7'sd1, 11'h400, 0, 0, 0, 16'h4000, 2);
    chk("beat count clear 2", bus.beat_cnt, 0);

    for (int i = 0; i < 150; i++) begin
      rs = 1'($urandom_range(0, 1));
      re = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) rm = 11'($urandom_range(0, 15));
      else                           rm = 11'($urandom_range(0, 2047));
      r  = $urandom_range(0, 15);
      rn = (r == 0);
      rp = (r == 1);
      ri = (r == 2);
      model(rs, int'($signed(re)), int'(rm), rn, rp, ri, ed, el);
      run_op($sformatf("rand%0d", i), rs, re, rm, rn, rp, ri, ed, el);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
